// File: rtl/stream_depacketizer.sv
// Splits a raw beat stream into header + payload packets; forwards payload beats
// through a 2-entry skid FIFO and reports header info on a side channel.
module stream_depacketizer #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned LEN_BITS  = 16,
    parameter int unsigned CNT_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_bits,
    output logic                 out_last,
    output logic                 hdr_valid,
    output logic [LEN_BITS-1:0]  hdr_len,
    output logic [CNT_BITS-1:0]  pkt_count,
    output logic [CNT_BITS-1:0]  drop_count
);

    typedef enum logic {S_HDR, S_PAYLOAD} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [LEN_BITS-1:0]  rem_q;
    logic [LEN_BITS-1:0]  in_len;
    logic                 accept;
    logic                 hdr_take;
    logic                 drop;
    logic                 push;
    logic                 push_last;
    logic                 pkt_done;
    logic                 pop;
    logic [1:0]           fifo_count;
    logic [1:0]           count_d;
    logic [DATA_BITS-1:0] tail_bits;
    logic                 tail_last;

    assign in_len = in_bits[LEN_BITS-1:0];
    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_HDR;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR:     if (accept && (in_len != '0))            state_d = S_PAYLOAD;
            S_PAYLOAD: if (accept && (rem_q == LEN_BITS'(1)))   state_d = S_HDR;
            default:   state_d = S_HDR;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        hdr_take  = 1'b0;
        drop      = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        pkt_done  = 1'b0;
        case (state_q)
            S_HDR: begin
                hdr_take = accept;
                drop     = accept && (in_len == '0);
            end
            S_PAYLOAD: begin
                push      = accept;
                push_last = (rem_q == LEN_BITS'(1));
                pkt_done  = accept && (rem_q == LEN_BITS'(1));
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = fifo_count;
        if (push && !pop)      count_d = fifo_count + 2'(1);
        else if (!push && pop) count_d = fifo_count - 2'(1);
    end

    // Header side channel, remaining-beat counter, saturating statistics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q      <= '0;
            hdr_valid  <= 1'b0;
            hdr_len    <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            in_ready   <= 1'b0;
        end else begin
            hdr_valid <= hdr_take;
            if (hdr_take) begin
                hdr_len <= in_len;
                rem_q   <= in_len;
            end else if (push) begin
                rem_q <= rem_q - LEN_BITS'(1);
            end
            if (pkt_done && (pkt_count != '1))  pkt_count  <= pkt_count + CNT_BITS'(1);
            if (drop && (drop_count != '1))     drop_count <= drop_count + CNT_BITS'(1);
            // Registered ready: equals (state==HDR)|(count<2) on the current registers
            in_ready <= (state_d == S_HDR) || (count_d < 2'd2);
        end
    end

    // Two-entry skid FIFO: head drives the output port directly
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_bits   <= '0;
            out_last   <= 1'b0;
            tail_bits  <= '0;
            tail_last  <= 1'b0;
        end else begin
            fifo_count <= count_d;
            out_valid  <= (count_d != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        out_bits <= in_bits;
                        out_last <= push_last;
                    end else begin
                        tail_bits <= in_bits;
                        tail_last <= push_last;
                    end
                end
                2'b01: begin
                    out_bits <= tail_bits;
                    out_last <= tail_last;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        out_bits <= in_bits;
                        out_last <= push_last;
                    end else begin
                        out_bits  <= tail_bits;
                        out_last  <= tail_last;
                        tail_bits <= in_bits;
                        tail_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_depacketizer.sv
// Scoreboard bench for stream_depacketizer: payload beats are queued when accepted
// and compared in order when the DUT presents them.
module tb_stream_depacketizer;

    localparam int unsigned DW = 64;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_bits = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_bits;
    logic          out_last;
    logic          hdr_valid;
    logic [LW-1:0] hdr_len;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] drop_count;

    logic fixed_rdy = 1'b1;
    logic rnd_rdy   = 1'b1;
    bit   rand_mode = 1'b0;
    bit   lat_chk   = 1'b0;
    assign out_ready = rand_mode ? rnd_rdy : fixed_rdy;

    typedef struct packed {
        logic [63:0] bits;
        logic        last;
        logic [31:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   hdr_seen = 0;

    stream_depacketizer #(.DATA_BITS(DW), .LEN_BITS(LW), .CNT_BITS(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bits   (out_bits),
        .out_last   (out_last),
        .hdr_valid  (hdr_valid),
        .hdr_len    (hdr_len),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #2;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability, header pulse count
    logic        prev_stall = 1'b0;
    logic [63:0] prev_bits  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (hdr_valid) hdr_seen++;
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_bits", out_bits, prev_bits);
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bits", out_bits, e.bits);
                    check("out_last", 64'(out_last), 64'(e.last));
                    if (lat_chk) check("latency", 64'(cyc - int'(e.acc)), 64'd1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bits  = out_bits;
            prev_last  = out_last;
        end
    end

    // Drive one beat from a negedge; returns at the negedge after acceptance
    task automatic send(input logic [63:0] d, input bit payload, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_bits  = d;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            if (payload) exp_q.push_back('{d, last, 32'(cyc)});
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_pkt(input int len, input logic [63:0] base);
        send(64'(len), 1'b0, 1'b0);
        for (int i = 0; i < len; i++) send(base + 64'(i), 1'b1, i == len - 1);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        hdr_seen = 0;
        @(negedge clock);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #1 reset = 1'b0;
        // Reset held with in_valid asserted
        in_valid = 1'b1;
        in_bits  = 64'h3;
        repeat (5) @(negedge clock);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bits", out_bits, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        check("rst_hdr_len", 64'(hdr_len), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Basic packet with one-cycle latency
        do_reset(2);
        fixed_rdy = 1'b1;
        lat_chk   = 1'b1;
        send_pkt(3, 64'hA);
        wait_drain();
        lat_chk = 1'b0;
        check("t2_hdr_pulses", 64'(hdr_seen), 64'd1);
        check("t2_hdr_len", 64'(hdr_len), 64'd3);
        check("t2_pkt_count", 64'(pkt_count), 64'd1);

        // Zero-length header then single-beat packet
        do_reset(2);
        send(64'd0, 1'b0, 1'b0);
        send_pkt(1, 64'h55);
        wait_drain();
        check("t3_drop_count", 64'(drop_count), 64'd1);
        check("t3_pkt_count", 64'(pkt_count), 64'd1);
        check("t3_hdr_pulses", 64'(hdr_seen), 64'd2);

        // Backpressure: FIFO fills, in_ready drops, order preserved
        do_reset(2);
        fixed_rdy = 1'b0;
        send(64'd4, 1'b0, 1'b0);
        send(64'h41, 1'b1, 1'b0);
        send(64'h42, 1'b1, 1'b0);
        check("t4_full_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_bits  = 64'h43;
        repeat (3) @(negedge clock);
        check("t4_still_blocked", 64'(in_ready), 64'd0);
        check("t4_head_valid", 64'(out_valid), 64'd1);
        check("t4_head_bits", out_bits, 64'h41);
        fixed_rdy = 1'b1;
        send(64'h43, 1'b1, 1'b0);
        send(64'h44, 1'b1, 1'b1);
        wait_drain();
        check("t4_pkt_count", 64'(pkt_count), 64'd1);

        // Reset mid-packet discards partial data
        do_reset(2);
        fixed_rdy = 1'b0;
        send(64'd4, 1'b0, 1'b0);
        send(64'h51, 1'b1, 1'b0);
        send(64'h52, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("t5_async_out_valid", 64'(out_valid), 64'd0);
        check("t5_async_in_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        hdr_seen  = 0;
        fixed_rdy = 1'b1;
        @(negedge clock);
        send_pkt(1, 64'h77);
        wait_drain();
        check("t5_pkt_count", 64'(pkt_count), 64'd1);
        check("t5_hdr_len", 64'(hdr_len), 64'd1);

        // Back-to-back single-beat packets under random backpressure
        do_reset(2);
        rand_mode = 1'b1;
        for (int i = 0; i < 10; i++) send_pkt(1, 64'h600 + 64'(i));
        wait_drain();
        rand_mode = 1'b0;
        check("t6_pkt_count", 64'(pkt_count), 64'd10);
        check("t6_hdr_pulses", 64'(hdr_seen), 64'd10);

        // Header upper bits ignored
        do_reset(2);
        send(64'hABCD_0000_1234_0002, 1'b0, 1'b0);
        send(64'h71, 1'b1, 1'b0);
        send(64'h72, 1'b1, 1'b1);
        wait_drain();
        check("t7_hdr_len", 64'(hdr_len), 64'd2);
        check("t7_pkt_count", 64'(pkt_count), 64'd1);

        // Drop counter saturates
        do_reset(2);
        for (int i = 0; i < 300; i++) send(64'hFFFF_0000, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check("t8_drop_sat", 64'(drop_count), 64'd255);
        check("t8_pkt_count", 64'(pkt_count), 64'd0);
        check("t8_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
